ili9341_window_streamer: RTL and testbench
==========================================

// Module: ili9341_window_streamer
// PURPOSE
//  Parametrised successor to the fixed full-screen ILI9341 pixel pump: streams an arbitrary rectangular
//  window (x0..x1, y0..y1) of VRAM to the panel. It issues CASET/PASET/RAMWR, then pixels, over the
//  existing spi_controller valid/ready interface. It sits after the init sequencer; single-shot or continuous refresh.
// PARAMETERS
//  DISPLAY_WIDTH   240            panel columns; VRAM row pitch
//  DISPLAY_HEIGHT  320            panel rows
//  VRAM_L          W*H            VRAM depth in pixels
//  VRAM_LATENCY    1              cycles from vram_rd_addr change to valid vram_rd_data (>=1)
// PORTS
//  clk            in   1    system clock
//  rstb           in   1    asynchronous, active-low reset
//  ena            in   1    advance enable; low freezes FSM (an offered SPI word stays offered)
//  start          in   1    1-cycle request; latches win_* and continuous; ignored unless idle
//  win_x0,win_x1  in   9    inclusive column bounds
//  win_y0,win_y1  in   9    inclusive row bounds
//  continuous     in   1    1: repeat the frame until a frame ends with continuous low
//  busy           out  1    high from accepted start until return to idle
//  done           out  1    1-cycle pulse after last pixel of each frame is accepted
//  err            out  1    1-cycle pulse: start rejected (bad window)
//  i_valid        out  1    SPI word offered
//  i_ready        in   1    SPI controller accepts word when i_valid & i_ready
//  i_data         out  16   byte in [7:0] ({8'd0,byte}) or RGB565 pixel
//  spi_mode       out  spi_transaction_t   WRITE_8 for cmd/args, WRITE_16 for pixels
//  data_commandb  out  1    0 while a command byte is offered, else 1
//  vram_rd_addr   out  $clog2(VRAM_L)   y*DISPLAY_WIDTH + x
//  vram_rd_data   in   16 (ILI9341_color_t)   pixel read data
//  hsync,vsync    out  1    high while last pixel of a window row / of the window is offered
// BEHAVIOUR
//  Reset (rstb=0, immediate): state IDLE; busy=done=err=i_valid=hsync=vsync=0; data_commandb=1;
//   spi_mode=WRITE_8; i_data=0; vram_rd_addr=0; counters 0.
//  Handshake: i_valid stays high with i_data/spi_mode/data_commandb stable until the accept cycle;
//   the next word is offered no earlier than the following cycle.
//  States: IDLE -> SEQ -> PIX_FETCH -> PIX_TX -> (PIX_FETCH | SEQ | IDLE).
//  IDLE: on start&ena, check x0<=x1<W and y0<=y1<H. Fail: err pulse next cycle, stay IDLE, no SPI.
//   Pass: latch window and continuous, busy=1, enter SEQ at index 0.
//  SEQ index 0..10, one WRITE_8 word each: 0x2A, x0[15:8], x0[7:0], x1[15:8], x1[7:0], 0x2B,
//   y0 hi/lo, y1 hi/lo, 0x2C. Coordinates are zero-extended to 16 bits.
//   data_commandb=0 at indices 0,5,10 only. After index 10 is accepted: x=x0, y=y0, go to PIX_FETCH.
//  PIX_FETCH: drive vram_rd_addr, wait VRAM_LATENCY cycles, register vram_rd_data -> PIX_TX.
//  PIX_TX: offer the pixel (WRITE_16, dc=1). On accept:
//   - if x<x1: x++;
//   - else x=x0; if y<y1: y++;
//   - else end of frame: done pulse; continuous=1 -> SEQ index 10 (RAMWR only, window unchanged);
//     otherwise -> IDLE, busy=0 the cycle after done.
//  continuous is re-sampled at every frame end. Clearing it stops refresh after the current frame; no mid-frame abort.
//  Pixels per frame = (x1-x0+1)*(y1-y0+1). A 1x1 window is legal. Address product uses $clog2(VRAM_L) bits.
//  start while busy: ignored, no err. start and frame end in the same cycle: start ignored.
//  ena low mid-handshake: i_valid held; acceptance still registers and state advances when ena returns.
// TESTING
//  1. Window (0,0)-(1,1), VRAM = 0x1111,0x2222 row0 / 0x3333,0x4444 row1, i_ready always 1 ->
//     words 2A,00,00,00,01,2B,00,00,00,01,2C (dc low on 1st/6th/11th), then 1111,2222,3333,4444;
//     hsync on 2222/4444; vsync+done on 4444; busy falls next cycle.
//  2. Full screen (0,0)-(239,319) -> CASET args 00,00,00,EF; PASET args 00,00,01,3F;
//     76800 pixels; last vram_rd_addr 76799.
//  3. start with x0=10,x1=5 and with y1=320 -> err pulse each time, busy=0, no i_valid.
//  4. continuous=1, 2x2 window, 3 frames, then drop continuous -> each repeat starts with one 2C
//     (dc=0), 3 done pulses, then IDLE.
//  5. i_ready randomly low, ena toggled -> no word lost or duplicated; i_data stable while i_valid.
//  6. rstb asserted mid-pixel -> all outputs at reset values the same cycle; a new start then runs cleanly.

Source files
------------

// File: rtl/ili9341_window_streamer.sv
// ili9341_window_streamer
// Streams a rectangular window (x0..x1, y0..y1) of VRAM to an ILI9341 panel
// through the spi_controller valid/ready interface. A frame is the sequence
// CASET (0x2A + 4 argument bytes), PASET (0x2B + 4 argument bytes), RAMWR
// (0x2C), followed by the window's pixels in row-major order. In continuous
// mode every later frame re-issues only RAMWR, because the panel keeps the
// column/page window from the first frame.
//
// Ports
//   clk, rstb           clock, asynchronous active-low reset
//   ena                 advance enable; low freezes the sequencer (an offered word stays offered)
//   start               one-cycle request, honoured only while idle
//   win_x0..win_y1      inclusive window bounds (9 bits each)
//   continuous          repeat frames while high; sampled at each frame end
//   busy / done / err   status: active, end-of-frame pulse, rejected-start pulse
//   i_valid/i_ready     word handshake towards the SPI controller
//   i_data              {8'h00, byte} for commands/arguments, RGB565 for pixels
//   spi_mode            0 = WRITE_8 (command/argument byte), 1 = WRITE_16 (pixel)
//   data_commandb       0 while a command byte is offered, 1 otherwise
//   vram_rd_addr        y*DISPLAY_WIDTH + x
//   vram_rd_data        pixel read data, valid VRAM_LATENCY cycles after an address change
//   hsync / vsync       high while the last pixel of a window row / of the window is offered
module ili9341_window_streamer #(
    parameter int DISPLAY_WIDTH  = 240,
    parameter int DISPLAY_HEIGHT = 320,
    parameter int VRAM_L         = DISPLAY_WIDTH * DISPLAY_HEIGHT,
    parameter int VRAM_LATENCY   = 1
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic                      ena,
    input  logic                      start,
    input  logic [8:0]                win_x0,
    input  logic [8:0]                win_x1,
    input  logic [8:0]                win_y0,
    input  logic [8:0]                win_y1,
    input  logic                      continuous,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic                      i_valid,
    input  logic                      i_ready,
    output logic [15:0]               i_data,
    output logic                      spi_mode,
    output logic                      data_commandb,
    output logic [$clog2(VRAM_L)-1:0] vram_rd_addr,
    input  logic [15:0]               vram_rd_data,
    output logic                      hsync,
    output logic                      vsync
);

    localparam int AW = $clog2(VRAM_L);
    localparam int LW = (VRAM_LATENCY < 1) ? 1 : $clog2(VRAM_LATENCY + 1);
    localparam logic [LW-1:0] LAT   = LW'(VRAM_LATENCY);
    localparam logic [15:0]   W16   = 16'(DISPLAY_WIDTH);
    localparam logic [15:0]   H16   = 16'(DISPLAY_HEIGHT);
    localparam logic [AW-1:0] PITCH = AW'(DISPLAY_WIDTH);
    localparam logic WRITE_8  = 1'b0;
    localparam logic WRITE_16 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEQ       = 2'd1,
        ST_PIX_FETCH = 2'd2,
        ST_PIX_TX    = 2'd3
    } state_t;

    // Byte offered at each command-sequence index (coordinates zero-extended to 16 bits).
    function automatic logic [7:0] seq_byte(input logic [3:0] idx,
                                            input logic [8:0] cx0, input logic [8:0] cx1,
                                            input logic [8:0] cy0, input logic [8:0] cy1);
        logic [15:0] ex0, ex1, ey0, ey1;
        ex0 = {7'd0, cx0};
        ex1 = {7'd0, cx1};
        ey0 = {7'd0, cy0};
        ey1 = {7'd0, cy1};
        case (idx)
            4'd0:    seq_byte = 8'h2A;
            4'd1:    seq_byte = ex0[15:8];
            4'd2:    seq_byte = ex0[7:0];
            4'd3:    seq_byte = ex1[15:8];
            4'd4:    seq_byte = ex1[7:0];
            4'd5:    seq_byte = 8'h2B;
            4'd6:    seq_byte = ey0[15:8];
            4'd7:    seq_byte = ey0[7:0];
            4'd8:    seq_byte = ey1[15:8];
            4'd9:    seq_byte = ey1[7:0];
            4'd10:   seq_byte = 8'h2C;
            default: seq_byte = 8'h00;
        endcase
    endfunction

    // Row-major VRAM address of pixel (px, py).
    function automatic logic [AW-1:0] pix_addr(input logic [8:0] px, input logic [8:0] py);
        pix_addr = AW'(py) * PITCH + AW'(px);
    endfunction

    state_t          state_r, state_nxt_s;
    logic [3:0]      idx_r, idx_nxt_s;
    logic [LW-1:0]   wait_r, wait_nxt_s;
    logic [8:0]      x0_r, x1_r, y0_r, y1_r, x_r, y_r;
    logic [8:0]      x0_nxt_s, x1_nxt_s, y0_nxt_s, y1_nxt_s, x_nxt_s, y_nxt_s;
    logic [15:0]     pix_r, pix_nxt_s;
    logic            acked_r, acked_nxt_s;
    logic            busy_r, busy_nxt_s;
    logic            done_r, done_nxt_s;
    logic            err_r, err_nxt_s;
    logic            valid_r, valid_nxt_s;
    logic [15:0]     data_r, data_nxt_s;
    logic            mode_r, mode_nxt_s;
    logic            dc_r, dc_nxt_s;
    logic [AW-1:0]   addr_r, addr_nxt_s;
    logic            hsync_r, hsync_nxt_s;
    logic            vsync_r, vsync_nxt_s;

    logic            accept_s;
    logic            advance_s;
    logic            offer_s;
    logic            win_ok_s;

    assign accept_s  = valid_r & i_ready;
    // acked_r remembers a word taken while ena was low, so the step happens once ena returns
    assign advance_s = (accept_s | acked_r) & ena;
    assign offer_s   = ~valid_r & ~acked_r & ena;
    assign win_ok_s  = (win_x0 <= win_x1) && ({7'd0, win_x1} < W16) &&
                       (win_y0 <= win_y1) && ({7'd0, win_y1} < H16);

    assign busy          = busy_r;
    assign done          = done_r;
    assign err           = err_r;
    assign i_valid       = valid_r;
    assign i_data        = data_r;
    assign spi_mode      = mode_r;
    assign data_commandb = dc_r;
    assign vram_rd_addr  = addr_r;
    assign hsync         = hsync_r;
    assign vsync         = vsync_r;

    // Next-state and next-output computation for the sequencer.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        wait_nxt_s  = wait_r;
        x0_nxt_s    = x0_r;
        x1_nxt_s    = x1_r;
        y0_nxt_s    = y0_r;
        y1_nxt_s    = y1_r;
        x_nxt_s     = x_r;
        y_nxt_s     = y_r;
        pix_nxt_s   = pix_r;
        acked_nxt_s = acked_r;
        busy_nxt_s  = busy_r;
        done_nxt_s  = 1'b0;
        err_nxt_s   = 1'b0;
        valid_nxt_s = valid_r;
        data_nxt_s  = data_r;
        mode_nxt_s  = mode_r;
        dc_nxt_s    = dc_r;
        addr_nxt_s  = addr_r;
        hsync_nxt_s = hsync_r;
        vsync_nxt_s = vsync_r;

        if (accept_s) begin
            valid_nxt_s = 1'b0;
            hsync_nxt_s = 1'b0;
            vsync_nxt_s = 1'b0;
            acked_nxt_s = ~ena;
        end else if (acked_r && ena) begin
            acked_nxt_s = 1'b0;
        end else begin
            acked_nxt_s = acked_r;
        end

        case (state_r)
            ST_IDLE: begin
                // busy lingers one cycle past the done pulse, so a start then is still ignored
                busy_nxt_s = 1'b0;
                if (start && ena && !busy_r) begin
                    if (win_ok_s) begin
                        x0_nxt_s    = win_x0;
                        x1_nxt_s    = win_x1;
                        y0_nxt_s    = win_y0;
                        y1_nxt_s    = win_y1;
                        busy_nxt_s  = 1'b1;
                        idx_nxt_s   = 4'd0;
                        state_nxt_s = ST_SEQ;
                    end else begin
                        err_nxt_s = 1'b1;
                    end
                end else begin
                    err_nxt_s = 1'b0;
                end
            end
            ST_SEQ: begin
                if (advance_s) begin
                    if (idx_r == 4'd10) begin
                        x_nxt_s     = x0_r;
                        y_nxt_s     = y0_r;
                        addr_nxt_s  = pix_addr(x0_r, y0_r);
                        wait_nxt_s  = '0;
                        state_nxt_s = ST_PIX_FETCH;
                    end else begin
                        idx_nxt_s = idx_r + 4'd1;
                    end
                end else if (offer_s) begin
                    valid_nxt_s = 1'b1;
                    data_nxt_s  = {8'h00, seq_byte(idx_r, x0_r, x1_r, y0_r, y1_r)};
                    mode_nxt_s  = WRITE_8;
                    dc_nxt_s    = ~((idx_r == 4'd0) || (idx_r == 4'd5) || (idx_r == 4'd10));
                end else begin
                    idx_nxt_s = idx_r;
                end
            end
            ST_PIX_FETCH: begin
                if (ena) begin
                    if (wait_r == LAT) begin
                        pix_nxt_s   = vram_rd_data;
                        state_nxt_s = ST_PIX_TX;
                    end else begin
                        wait_nxt_s = wait_r + {{(LW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    wait_nxt_s = wait_r;
                end
            end
            ST_PIX_TX: begin
                if (advance_s) begin
                    if (x_r < x1_r) begin
                        x_nxt_s     = x_r + 9'd1;
                        addr_nxt_s  = pix_addr(x_r + 9'd1, y_r);
                        wait_nxt_s  = '0;
                        state_nxt_s = ST_PIX_FETCH;
                    end else if (y_r < y1_r) begin
                        x_nxt_s     = x0_r;
                        y_nxt_s     = y_r + 9'd1;
                        addr_nxt_s  = pix_addr(x0_r, y_r + 9'd1);
                        wait_nxt_s  = '0;
                        state_nxt_s = ST_PIX_FETCH;
                    end else begin
                        // End of frame: the panel window is already set, so a repeat needs only RAMWR
                        done_nxt_s = 1'b1;
                        if (continuous) begin
                            idx_nxt_s   = 4'd10;
                            state_nxt_s = ST_SEQ;
                        end else begin
                            state_nxt_s = ST_IDLE;
                        end
                    end
                end else if (offer_s) begin
                    valid_nxt_s = 1'b1;
                    data_nxt_s  = pix_r;
                    mode_nxt_s  = WRITE_16;
                    dc_nxt_s    = 1'b1;
                    hsync_nxt_s = (x_r == x1_r);
                    vsync_nxt_s = (x_r == x1_r) && (y_r == y1_r);
                end else begin
                    x_nxt_s = x_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_r <= ST_IDLE;
            idx_r   <= 4'd0;
            wait_r  <= '0;
            x0_r    <= 9'd0;
            x1_r    <= 9'd0;
            y0_r    <= 9'd0;
            y1_r    <= 9'd0;
            x_r     <= 9'd0;
            y_r     <= 9'd0;
            pix_r   <= 16'd0;
            acked_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            valid_r <= 1'b0;
            data_r  <= 16'd0;
            mode_r  <= WRITE_8;
            dc_r    <= 1'b1;
            addr_r  <= '0;
            hsync_r <= 1'b0;
            vsync_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
            wait_r  <= wait_nxt_s;
            x0_r    <= x0_nxt_s;
            x1_r    <= x1_nxt_s;
            y0_r    <= y0_nxt_s;
            y1_r    <= y1_nxt_s;
            x_r     <= x_nxt_s;
            y_r     <= y_nxt_s;
            pix_r   <= pix_nxt_s;
            acked_r <= acked_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
            err_r   <= err_nxt_s;
            valid_r <= valid_nxt_s;
            data_r  <= data_nxt_s;
            mode_r  <= mode_nxt_s;
            dc_r    <= dc_nxt_s;
            addr_r  <= addr_nxt_s;
            hsync_r <= hsync_nxt_s;
            vsync_r <= vsync_nxt_s;
        end
    end

endmodule

// File: tb/tb_ili9341_window_streamer.sv
// tb_ili9341_window_streamer
// Self-checking bench for ili9341_window_streamer. A reference model builds the
// expected list of SPI words for a window directly from the panel protocol
// (CASET/PASET/RAMWR bytes, then row-major pixels read from a VRAM array) and
// the words accepted by the handshake are compared against it.
module tb_ili9341_window_streamer;

    localparam int   W   = 240;
    localparam int   H   = 320;
    localparam logic M8  = 1'b0;
    localparam logic M16 = 1'b1;

    logic        clk = 1'b0;
    logic        rstb = 1'b1;
    logic        ena = 1'b1;
    logic        start = 1'b0;
    logic [8:0]  win_x0 = 9'd0, win_x1 = 9'd0, win_y0 = 9'd0, win_y1 = 9'd0;
    logic        continuous = 1'b0;
    logic        i_ready = 1'b1;
    logic        busy, done, err, i_valid, spi_mode, data_commandb, hsync, vsync;
    logic [15:0] i_data;
    logic [16:0] vram_rd_addr;
    logic [15:0] vram_rd_data = 16'd0;

    logic [15:0] mem [0:W*H-1];
    logic [19:0] got_q[$];
    logic [19:0] exp_q[$];
    int          n_assert = 0;
    int          n_fail = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          valid_cnt = 0;
    logic        rand_rdy = 1'b0;
    logic        rand_ena = 1'b0;
    logic        prev_hold = 1'b0;
    logic [19:0] prev_word = 20'd0;

    always #5 clk = ~clk;

    ili9341_window_streamer #(
        .DISPLAY_WIDTH (W),
        .DISPLAY_HEIGHT(H),
        .VRAM_LATENCY  (1)
    ) dut (
        .clk          (clk),
        .rstb         (rstb),
        .ena          (ena),
        .start        (start),
        .win_x0       (win_x0),
        .win_x1       (win_x1),
        .win_y0       (win_y0),
        .win_y1       (win_y1),
        .continuous   (continuous),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .i_valid      (i_valid),
        .i_ready      (i_ready),
        .i_data       (i_data),
        .spi_mode     (spi_mode),
        .data_commandb(data_commandb),
        .vram_rd_addr (vram_rd_addr),
        .vram_rd_data (vram_rd_data),
        .hsync        (hsync),
        .vsync        (vsync)
    );

    // Synchronous VRAM: one cycle of read latency.
    always @(posedge clk) vram_rd_data <= mem[vram_rd_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] wd(input logic dc, input logic m, input logic hs,
                                       input logic vs, input logic [15:0] d);
        return {dc, m, hs, vs, d};
    endfunction

    // Expected word list for one frame; full=0 gives a continuous-mode repeat (RAMWR only).
    task automatic build_exp(input int x0, input int x1, input int y0, input int y1, input bit full);
        if (full) begin
            exp_q.push_back(wd(1'b0, M8, 1'b0, 1'b0, 16'h002A));
            exp_q.push_back(wd(1'b1, M8, 1'b0, 1'b0, 16'(x0 >> 8)));
            exp_q.push_back(wd(1'b1, M8, 1'b0, 1'b0, 16'(x0 & 255)));
            exp_q.push_back(wd(1'b1, M8, 1'b0, 1'b0, 16'(x1 >> 8)));
            exp_q.push_back(wd(1'b1, M8, 1'b0, 1'b0, 16'(x1 & 255)));
            exp_q.push_back(wd(1'b0, M8, 1'b0, 1'b0, 16'h002B));
            exp_q.push_back(wd(1'b1, M8, 1'b0, 1'b0, 16'(y0 >> 8)));
            exp_q.push_back(wd(1'b1, M8, 1'b0, 1'b0, 16'(y0 & 255)));
            exp_q.push_back(wd(1'b1, M8, 1'b0, 1'b0, 16'(y1 >> 8)));
            exp_q.push_back(wd(1'b1, M8, 1'b0, 1'b0, 16'(y1 & 255)));
        end
        exp_q.push_back(wd(1'b0, M8, 1'b0, 1'b0, 16'h002C));
        for (int y = y0; y <= y1; y++) begin
            for (int x = x0; x <= x1; x++) begin
                exp_q.push_back(wd(1'b1, M16, x == x1, (x == x1) && (y == y1), mem[y*W + x]));
            end
        end
    endtask

    // Compare captured words with the model; exact=1 also requires equal length.
    task automatic compare_q(input string tag, input bit exact);
        int n;
        if (exact) check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s[%0d]", tag, i), {12'd0, got_q[i]}, {12'd0, exp_q[i]});
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic start_win(input int x0, input int x1, input int y0, input int y1, input logic cont);
        @(posedge clk); #1;
        win_x0 = 9'(x0); win_x1 = 9'(x1); win_y0 = 9'(y0); win_y1 = 9'(y1);
        continuous = cont;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Waits (bounded) until the done-pulse count reaches target; returns in the done cycle.
    task automatic wait_done(input int target, input int budget, input string tag);
        int c = 0;
        while (done_cnt < target && c < budget) begin
            @(negedge clk); #1;
            c++;
        end
        check({tag, "_done_reached"}, 32'(done_cnt >= target), 32'd1);
    endtask

    // Checks the last done of a non-continuous run and that busy drops one cycle later.
    task automatic end_of_run(input string tag);
        check({tag, "_done_pulse"}, 32'(done), 32'd1);
        check({tag, "_busy_at_done"}, 32'(busy), 32'd1);
        @(negedge clk); #1;
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_done_width"}, 32'(done), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_valid"}, 32'(i_valid), 32'd0);
        check({tag, "_hsync"}, 32'(hsync), 32'd0);
        check({tag, "_vsync"}, 32'(vsync), 32'd0);
        check({tag, "_dc"}, 32'(data_commandb), 32'd1);
        check({tag, "_mode"}, 32'(spi_mode), 32'(M8));
        check({tag, "_data"}, 32'(i_data), 32'd0);
        check({tag, "_addr"}, 32'(vram_rd_addr), 32'd0);
    endtask

    // Handshake monitor: records accepted words and checks an offered word holds until taken.
    always @(negedge clk) begin
        if (prev_hold && rstb) begin
            check("hold_valid", 32'(i_valid), 32'd1);
            check("hold_word", {12'd0, data_commandb, spi_mode, hsync, vsync, i_data}, {12'd0, prev_word});
        end
        if (i_valid && i_ready) got_q.push_back({data_commandb, spi_mode, hsync, vsync, i_data});
        prev_hold = rstb && i_valid && !i_ready;
        prev_word = {data_commandb, spi_mode, hsync, vsync, i_data};
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (i_valid) valid_cnt++;
    end

    // Random back-pressure and enable stalls; ena is forced high while start is asserted.
    initial begin
        forever begin
            @(posedge clk); #2;
            i_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            ena     = (rand_ena && !start) ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    initial begin
        int base;
        int c;
        int e0, v0;
        int x0, x1, y0, y1;

        for (int i = 0; i < W*H; i++) mem[i] = 16'($urandom);
        mem[0]   = 16'h1111;
        mem[1]   = 16'h2222;
        mem[W]   = 16'h3333;
        mem[W+1] = 16'h4444;

        // Reset state
        #1 rstb = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rstb = 1'b1;

        // 2x2 window at origin
        base = done_cnt;
        start_win(0, 1, 0, 1, 1'b0);
        check("t1_busy", 32'(busy), 32'd1);
        build_exp(0, 1, 0, 1, 1'b1);
        wait_done(base + 1, 2000, "t1");
        check("t1_addr_last", 32'(vram_rd_addr), 32'(W + 1));
        end_of_run("t1");
        check("t1_x1_lo", {16'd0, got_q[4][15:0]}, 32'h0001);
        check("t1_pix0", {12'd0, got_q[11]}, {12'd0, 1'b1, M16, 1'b0, 1'b0, 16'h1111});
        check("t1_pix3", {12'd0, got_q[14]}, {12'd0, 1'b1, M16, 1'b1, 1'b1, 16'h4444});
        compare_q("t1", 1'b1);

        // Rejected windows: reversed columns, row beyond panel, column beyond panel
        for (int k = 0; k < 3; k++) begin
            e0 = err_cnt;
            v0 = valid_cnt;
            if (k == 0) start_win(10, 5, 0, 0, 1'b0);
            else if (k == 1) start_win(0, 0, 0, 320, 1'b0);
            else start_win(0, 240, 0, 0, 1'b0);
            check($sformatf("t3_err_%0d", k), 32'(err), 32'd1);
            check($sformatf("t3_busy_%0d", k), 32'(busy), 32'd0);
            repeat (3) @(posedge clk);
            #1;
            check($sformatf("t3_err_count_%0d", k), 32'(err_cnt - e0), 32'd1);
            check($sformatf("t3_no_valid_%0d", k), 32'(valid_cnt - v0), 32'd0);
        end

        // Full screen: check the window commands, then reset while a pixel is offered
        start_win(0, 239, 0, 319, 1'b0);
        c = 0;
        while (!(i_valid && spi_mode == M16) && c < 500) begin
            @(negedge clk); #1;
            c++;
        end
        check("t2_pixel_offered", 32'(i_valid && spi_mode == M16), 32'd1);
        check("t2_caset_x1_lo", {16'd0, got_q[4][15:0]}, 32'h00EF);
        check("t2_paset_y1_hi", {16'd0, got_q[8][15:0]}, 32'h0001);
        check("t2_paset_y1_lo", {16'd0, got_q[9][15:0]}, 32'h003F);
        build_exp(0, 239, 0, 319, 1'b1);
        compare_q("t2", 1'b0);
        rstb = 1'b0;
        #1 check_reset_outputs("t6_midreset");
        @(posedge clk); #1;
        rstb = 1'b1;
        got_q.delete();

        // Clean run after reset: bottom-right 1x1 (last VRAM address) and 4x3 corner
        base = done_cnt;
        start_win(239, 239, 319, 319, 1'b0);
        build_exp(239, 239, 319, 319, 1'b1);
        wait_done(base + 1, 2000, "t6a");
        check("t6a_addr_last", 32'(vram_rd_addr), 32'd76799);
        end_of_run("t6a");
        compare_q("t6a", 1'b1);

        base = done_cnt;
        start_win(236, 239, 317, 319, 1'b0);
        build_exp(236, 239, 317, 319, 1'b1);
        wait_done(base + 1, 3000, "t6b");
        end_of_run("t6b");
        compare_q("t6b", 1'b1);

        // Continuous refresh: three frames, continuous dropped during the third
        base = done_cnt;
        start_win(5, 6, 7, 8, 1'b1);
        build_exp(5, 6, 7, 8, 1'b1);
        build_exp(5, 6, 7, 8, 1'b0);
        build_exp(5, 6, 7, 8, 1'b0);
        wait_done(base + 2, 3000, "t4_second");
        check("t4_busy_mid", 32'(busy), 32'd1);
        continuous = 1'b0;
        wait_done(base + 3, 3000, "t4_third");
        end_of_run("t4");
        repeat (20) @(posedge clk);
        #1;
        check("t4_done_total", 32'(done_cnt - base), 32'd3);
        compare_q("t4", 1'b1);

        // Random windows with back-pressure and ena stalls; a start while busy is ignored
        rand_rdy = 1'b1;
        rand_ena = 1'b1;
        for (int k = 0; k < 4; k++) begin
            x0 = $urandom_range(0, W - 1);
            x1 = x0 + $urandom_range(0, (W - 1 - x0) < 3 ? (W - 1 - x0) : 3);
            y0 = $urandom_range(0, H - 1);
            y1 = y0 + $urandom_range(0, (H - 1 - y0) < 3 ? (H - 1 - y0) : 3);
            base = done_cnt;
            e0 = err_cnt;
            start_win(x0, x1, y0, y1, 1'b0);
            build_exp(x0, x1, y0, y1, 1'b1);
            repeat (3) @(posedge clk);
            start_win(10, 5, 0, 0, 1'b0);
            wait_done(base + 1, 4000, $sformatf("t5_%0d", k));
            end_of_run($sformatf("t5_%0d", k));
            check($sformatf("t5_no_err_%0d", k), 32'(err_cnt - e0), 32'd0);
            compare_q($sformatf("t5_%0d", k), 1'b1);
        end
        rand_rdy = 1'b0;
        rand_ena = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #3000000;
        $display("FAIL watchdog: observed simulation still running expected finished");
        $fatal(1, "watchdog expired");
    end

endmodule
